dpram: RTL and testbench
========================

Name: dpram

Overview:
- Single-clock, true dual-port synchronous RAM with two symmetric ports, A and B.
- Each port has a valid/ready request handshake: read or write, one transfer per port per cycle.
- Conflicting same-address accesses are resolved with fixed port-A priority.
- Sits as a shared scratch memory between two independent requesters. Each requester connects through a port_if bundle of addr, data, we, q, valid and ready.

Parameters:
- DATA_WIDTH, 8, width of each memory word.
- ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words (256).

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- addr_a  input  ADDR_WIDTH  port A word address.
- data_a  input  DATA_WIDTH  port A write data.
- we_a  input  1  port A write enable (1 = write, 0 = read), qualified by valid_a.
- valid_a  input  1  port A request valid.
- ready_a  output  1  port A can accept a request this cycle.
- q_a  output  DATA_WIDTH  port A read data.
- addr_b, data_b, we_b, valid_b  input  same as port A, for port B.
- ready_b  output  1  port B can accept a request this cycle.
- q_b  output  DATA_WIDTH  port B read data.

Behaviour:
- Reset: while rst_n=0 (asserted asynchronously), all memory words are 0, q_a=q_b=0 and ready_a=ready_b=0. Any request in flight is discarded.
- First clk edge after rst_n rises: ready outputs are already valid combinationally; no extra wait cycle.
- Transfer rule: a port's request is accepted at a rising clk edge when valid_x=1 and ready_x=1.
  - The requester holds addr, data and we stable while valid_x=1 and ready_x=0.
- ready_a: 1 whenever rst_n=1. Port A is never stalled.
- ready_b: combinational. It is 0 when all of the following hold, otherwise 1 (when rst_n=1):
  - valid_a=1 and valid_b=1;
  - addr_a==addr_b;
  - we_a=1 or we_b=1.
- Write: on acceptance, mem[addr] <= data at that edge; q_x is unchanged.
- Read: on acceptance, q_x <= mem[addr] at that edge. Latency is 1 cycle: data appears the cycle after the request.
  - Read data is the pre-edge memory content.
  - q_x holds its last value until the next accepted read on that port.
- Simultaneous accesses to different addresses: both ports are served in the same cycle, in any read/write mix.
- Simultaneous reads of the same address: both are served and return identical data.
- Same-address conflict with at least one write: port A is served and port B stalls one cycle. On the next cycle port B is served.
  - If B reads after A's write, B returns A's newly written data.
  - If B writes after A's read, A's q holds the old data.
- Idle (valid_x=0): no memory or q change on that port. we_x and data_x are ignored.
- Address wrap: addresses cover exactly DEPTH words. There is no out-of-range case, so the top address 2**ADDR_WIDTH-1 is a normal location.
- Reset mid-operation: everything clears immediately. A write accepted on the same edge that rst_n falls is lost.

Decomposition:
- Package dpram_pkg:
  - default DATA_WIDTH and ADDR_WIDTH constants;
  - a typedef for the port request (addr, data, we, valid), shared with port_if and the testbench.
- port_if: interface carrying addr, data, we, valid, ready and q, plus clk and rst_n inputs.
- One sub-module, dpram_arbiter: purely combinational same-address conflict detection, producing ready_a and ready_b.
- Storage array, write logic and read registers stay in dpram.

Test Plan:
- Reset check: assert rst_n=0 for 5 cycles, then release. q_a=q_b=0 and ready_a=ready_b=0 during reset; ready_a=ready_b=1 after. Reading any address (e.g. 0x10) returns 0x00.
- Port A write 0x3C to 0x05, then a port A read of 0x05 -> q_a=0x3C one cycle after the read is accepted. A port B read of 0x05 -> q_b=0x3C.
- Parallel distinct addresses: same cycle A writes 0xAA@0x01 and B writes 0x55@0xFF; both ready=1. Next cycle read both -> q_a=0xAA, q_b=0x55.
- Write collision: same cycle A writes 0x11@0x20 and B writes 0x22@0x20 -> ready_b=0 that cycle. B writes next cycle; a final read of 0x20 returns 0x22.
- Read-after-write conflict: A writes 0x77@0x40 while B reads 0x40 -> B stalls one cycle, then q_b=0x77.
- Mid-operation reset: write 0x99@0x08, pulse rst_n low for 1 cycle, read 0x08 -> q=0x00. q_a and q_b are 0 immediately upon rst_n falling.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared constants and request record for the dual-port scratch RAM.
package dpram_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
        logic                      we;
        logic                      valid;
    } port_req_t;

endpackage

// File: rtl/dpram_if.sv
// One requester's connection to the dual-port RAM: request, handshake and read data.
interface port_if
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input logic clk,
    input logic rst_n
);

    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  we;
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] q;

    modport master (
        input  clk, rst_n, ready, q,
        output addr, data, we, valid
    );

    modport slave (
        input  clk, rst_n, addr, data, we, valid,
        output ready, q
    );

endinterface

// File: rtl/dpram_arbiter.sv
// Same-address conflict detection; port A always wins, port B waits a cycle.
module dpram_arbiter
    import dpram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  rst_n,
    input  logic                  valid_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic                  valid_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic                  ready_a,
    output logic                  ready_b
);

    logic conflict;

    // Two reads of one word are harmless; any write to a shared word must be ordered.
    assign conflict = valid_a && valid_b && (addr_a == addr_b) && (we_a || we_b);
    assign ready_a  = rst_n;
    assign ready_b  = rst_n && !conflict;

endmodule

// File: rtl/dpram.sv
// True dual-port single-clock RAM with registered read data and fixed port-A priority.
module dpram
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    port_if.slave a,
    port_if.slave b
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] q_a_p1;
    logic [DATA_WIDTH-1:0] q_b_p1;
    logic                  ready_a;
    logic                  ready_b;
    logic                  acc_a;
    logic                  acc_b;

    dpram_arbiter #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_arbiter (
        .rst_n   (rst_n),
        .valid_a (a.valid),
        .we_a    (a.we),
        .addr_a  (a.addr),
        .valid_b (b.valid),
        .we_b    (b.we),
        .addr_b  (b.addr),
        .ready_a (ready_a),
        .ready_b (ready_b)
    );

    assign acc_a = a.valid && ready_a;
    assign acc_b = b.valid && ready_b;

    // The arbiter guarantees the two write addresses differ whenever both ports write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            q_a_p1 <= '0;
            q_b_p1 <= '0;
        end else begin
            if (acc_a && a.we) begin
                mem[a.addr] <= a.data;
            end
            if (acc_b && b.we) begin
                mem[b.addr] <= b.data;
            end
            if (acc_a && !a.we) begin
                q_a_p1 <= mem[a.addr];
            end
            if (acc_b && !b.we) begin
                q_b_p1 <= mem[b.addr];
            end
        end
    end

    assign a.ready = ready_a;
    assign b.ready = ready_b;
    assign a.q     = q_a_p1;
    assign b.q     = q_b_p1;

endmodule

// File: tb/tb_dpram.sv
// Directed table plus randomized traffic against a word-array model of the dual-port RAM.
module tb_dpram;
    import dpram_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    port_if pa (.clk(clk), .rst_n(rst_n));
    port_if pb (.clk(clk), .rst_n(rst_n));

    dpram dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (pa),
        .b     (pb)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        port_req_t  ra;
        port_req_t  rb;
        logic       rdy_b;
        logic [7:0] qa;
        logic [7:0] qb;
    } vec_t;

    vec_t vecs[15];

    logic [7:0] mem_m [256];
    logic [7:0] qa_m;
    logic [7:0] qb_m;

    function automatic port_req_t rq(input logic v, input logic w,
                                     input logic [7:0] ad, input logic [7:0] d);
        port_req_t r;
        r.valid = v;
        r.we    = w;
        r.addr  = ad;
        r.data  = d;
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input port_req_t ra, input port_req_t rb);
        pa.valid = ra.valid; pa.we = ra.we; pa.addr = ra.addr; pa.data = ra.data;
        pb.valid = rb.valid; pb.we = rb.we; pb.addr = rb.addr; pb.data = rb.data;
    endtask

    function automatic logic [7:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        return (sel < 8) ? 8'(sel) : 8'hFF;
    endfunction

    initial begin
        port_req_t  ra, rb;
        logic       exp_rb;
        logic       b_hold;

        // {port A request, port B request, ready_b, q_a after edge, q_b after edge}
        vecs[0]  = '{rq(1,0,8'h10,8'h00), rq(0,0,8'h00,8'h00), 1'b1, 8'h00, 8'h00};
        vecs[1]  = '{rq(1,1,8'h05,8'h3C), rq(0,0,8'h00,8'h00), 1'b1, 8'h00, 8'h00};
        vecs[2]  = '{rq(1,0,8'h05,8'h00), rq(1,0,8'h05,8'h00), 1'b1, 8'h3C, 8'h3C};
        vecs[3]  = '{rq(1,1,8'h01,8'hAA), rq(1,1,8'hFF,8'h55), 1'b1, 8'h3C, 8'h3C};
        vecs[4]  = '{rq(1,0,8'h01,8'h00), rq(1,0,8'hFF,8'h00), 1'b1, 8'hAA, 8'h55};
        vecs[5]  = '{rq(1,1,8'h20,8'h11), rq(1,1,8'h20,8'h22), 1'b0, 8'hAA, 8'h55};
        vecs[6]  = '{rq(0,0,8'h00,8'h00), rq(1,1,8'h20,8'h22), 1'b1, 8'hAA, 8'h55};
        vecs[7]  = '{rq(1,0,8'h20,8'h00), rq(0,0,8'h00,8'h00), 1'b1, 8'h22, 8'h55};
        vecs[8]  = '{rq(1,1,8'h40,8'h77), rq(1,0,8'h40,8'h00), 1'b0, 8'h22, 8'h55};
        vecs[9]  = '{rq(0,0,8'h00,8'h00), rq(1,0,8'h40,8'h00), 1'b1, 8'h22, 8'h77};
        vecs[10] = '{rq(1,0,8'h40,8'h00), rq(1,1,8'h40,8'h88), 1'b0, 8'h77, 8'h77};
        vecs[11] = '{rq(0,0,8'h00,8'h00), rq(1,1,8'h40,8'h88), 1'b1, 8'h77, 8'h77};
        vecs[12] = '{rq(1,0,8'h40,8'h00), rq(0,0,8'h00,8'h00), 1'b1, 8'h88, 8'h77};
        vecs[13] = '{rq(0,1,8'h40,8'hFF), rq(0,1,8'h40,8'hEE), 1'b1, 8'h88, 8'h77};
        vecs[14] = '{rq(1,0,8'h40,8'h00), rq(1,0,8'h01,8'h00), 1'b1, 8'h88, 8'hAA};

        rst_n = 1'b0;
        drive(rq(0,0,8'h00,8'h00), rq(0,0,8'h00,8'h00));
        repeat (5) @(posedge clk);
        #1;
        chk("rst_ready_a", 8'(pa.ready), 8'h00);
        chk("rst_ready_b", 8'(pb.ready), 8'h00);
        chk("rst_q_a", pa.q, 8'h00);
        chk("rst_q_b", pb.q, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready_a", 8'(pa.ready), 8'h01);
        chk("post_rst_ready_b", 8'(pb.ready), 8'h01);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].ra, vecs[i].rb);
            #1;
            chk($sformatf("vec%0d_ready_a", i), 8'(pa.ready), 8'h01);
            chk($sformatf("vec%0d_ready_b", i), 8'(pb.ready), 8'(vecs[i].rdy_b));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_q_a", i), pa.q, vecs[i].qa);
            chk($sformatf("vec%0d_q_b", i), pb.q, vecs[i].qb);
        end

        // Mid-operation reset: the stored word and both read registers must clear.
        @(negedge clk);
        drive(rq(1,1,8'h08,8'h99), rq(1,0,8'h05,8'h00));
        @(posedge clk);
        #1;
        chk("mid_pre_q_b", pb.q, 8'h3C);
        @(negedge clk);
        drive(rq(0,0,8'h00,8'h00), rq(0,0,8'h00,8'h00));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_q_a", pa.q, 8'h00);
        chk("mid_rst_q_b", pb.q, 8'h00);
        chk("mid_rst_ready_a", 8'(pa.ready), 8'h00);
        chk("mid_rst_ready_b", 8'(pb.ready), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(rq(1,0,8'h08,8'h00), rq(1,0,8'h05,8'h00));
        @(posedge clk);
        #1;
        chk("mid_read_q_a", pa.q, 8'h00);
        chk("mid_read_q_b", pb.q, 8'h00);

        // Randomized traffic over a few hot addresses plus the top word.
        foreach (mem_m[i]) mem_m[i] = 8'h00;
        qa_m   = 8'h00;
        qb_m   = 8'h00;
        b_hold = 1'b0;
        rb     = rq(0,0,8'h00,8'h00);
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            ra = rq(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    rand_addr(), 8'($urandom));
            if (!b_hold) begin
                rb = rq(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                        rand_addr(), 8'($urandom));
            end
            drive(ra, rb);
            exp_rb = !(ra.valid && rb.valid && ra.addr == rb.addr && (ra.we || rb.we));
            #1;
            chk("rnd_ready_a", 8'(pa.ready), 8'h01);
            chk("rnd_ready_b", 8'(pb.ready), 8'(exp_rb));
            if (ra.valid && !ra.we)           qa_m = mem_m[ra.addr];
            if (rb.valid && exp_rb && !rb.we) qb_m = mem_m[rb.addr];
            if (ra.valid && ra.we)            mem_m[ra.addr] = ra.data;
            if (rb.valid && exp_rb && rb.we)  mem_m[rb.addr] = rb.data;
            b_hold = rb.valid && !exp_rb;
            @(posedge clk);
            #1;
            chk("rnd_q_a", pa.q, qa_m);
            chk("rnd_q_b", pb.q, qb_m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
